// File: rtl/enemy_spawner.sv
// +------------------------------------------------------------------------+
// | enemy_spawner: enemy slot table with LFSR-placed, tick-paced spawning. |
// | Optional safe zone around the player: ENEMY_SPAWN_SAFE_ZONE_EN.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module enemy_spawner #(
  parameter int MAX_ENEMIES = 10,
  parameter int SPAWN_TICKS = 4,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int ENEMY_SIZE  = 20,
  parameter int SAFE_MARGIN = 40,
  parameter int MAX_RETRY   = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      clear_all,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic                      kill_valid,
  input  logic [3:0]                kill_idx,
  output logic                      kill_ready,
  output logic [MAX_ENEMIES-1:0]    enemy_active,
  output logic [10*MAX_ENEMIES-1:0] enemy_x_flat,
  output logic [10*MAX_ENEMIES-1:0] enemy_y_flat,
  output logic [3:0]                active_count,
  output logic                      spawn_pulse
);

  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_SCAN   = 3'd1;
  localparam logic [2:0]  S_GEN    = 3'd2;
  localparam logic [2:0]  S_CHECK  = 3'd3;
  localparam logic [2:0]  S_COMMIT = 3'd4;

  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;
  localparam logic [15:0] c_tick_last = 16'(SPAWN_TICKS - 1);
  localparam logic [3:0]  c_last_slot = 4'(MAX_ENEMIES - 1);
  localparam logic [9:0]  c_x_span    = 10'(SCREEN_W - ENEMY_SIZE);
  localparam logic [9:0]  c_y_span    = 10'(SCREEN_H - ENEMY_SIZE);
  localparam logic [7:0]  c_max_retry = 8'(MAX_RETRY);

  logic [2:0]             r_state;
  logic [2:0]             w_next_state;
  logic [15:0]            r_lfsr;
  logic [15:0]            w_lfsr_next;
  logic [15:0]            r_tick_cnt;
  logic                   r_spawn_req;
  logic [3:0]             r_ptr;
  logic [3:0]             r_target;
  logic [9:0]             r_cand_x;
  logic [9:0]             r_cand_y;
  logic [7:0]             r_retry;
  logic                   w_commit;
  logic                   w_slot_busy;
  logic                   w_reject;
  logic                   w_tick_wrap;
  logic                   w_req_done;
  logic                   w_kill_fire;
  logic [9:0]             w_rx;
  logic [9:0]             w_ry;
  logic [MAX_ENEMIES-1:0] w_kill_mask;
  logic [MAX_ENEMIES-1:0] w_commit_mask;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
  assign w_slot_busy = enemy_active[r_ptr];
  assign w_tick_wrap = tick && (r_tick_cnt == c_tick_last);
  assign w_kill_fire = kill_valid && kill_ready;
  assign w_rx        = r_lfsr[9:0];
  assign w_ry        = {1'b0, r_lfsr[15:7]};

`ifdef ENEMY_SPAWN_SAFE_ZONE_EN
  // Zone is the player box (ENEMY_SIZE square) grown by SAFE_MARGIN, low edge clamped at 0.
  localparam logic [10:0] c_size   = 11'(ENEMY_SIZE);
  localparam logic [10:0] c_margin = 11'(SAFE_MARGIN);
  logic [10:0] w_px, w_py, w_cx, w_cy;
  logic [10:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
  assign w_px     = {1'b0, player_x};
  assign w_py     = {1'b0, player_y};
  assign w_cx     = {1'b0, r_cand_x};
  assign w_cy     = {1'b0, r_cand_y};
  assign w_lo_x   = (w_px >= c_margin) ? (w_px - c_margin) : 11'd0;
  assign w_lo_y   = (w_py >= c_margin) ? (w_py - c_margin) : 11'd0;
  assign w_hi_x   = w_px + c_size + c_margin;
  assign w_hi_y   = w_py + c_size + c_margin;
  assign w_reject = ((w_cx + c_size) > w_lo_x) && (w_cx < w_hi_x) &&
                    ((w_cy + c_size) > w_lo_y) && (w_cy < w_hi_y);
`else
  logic w_unused;
  assign w_unused = &{1'b0, player_x, player_y};
  assign w_reject = 1'b0;
`endif

  assign w_req_done = ((r_state == S_SCAN) && w_slot_busy && (r_ptr == c_last_slot)) ||
                      ((r_state == S_CHECK) && w_reject && (r_retry == c_max_retry)) ||
                      w_commit;

  for (genvar i = 0; i < MAX_ENEMIES; i++) begin : g_slot
    assign w_kill_mask[i]   = w_kill_fire && (kill_idx == 4'(i)) && enemy_active[i];
    assign w_commit_mask[i] = w_commit && (r_target == 4'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear_all) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (r_spawn_req) w_next_state = S_SCAN;
        S_SCAN: begin
          if (!w_slot_busy)               w_next_state = S_GEN;
          else if (r_ptr == c_last_slot)  w_next_state = S_IDLE;
        end
        S_GEN:    w_next_state = S_CHECK;
        S_CHECK: begin
          if (!w_reject)                  w_next_state = S_COMMIT;
          else if (r_retry == c_max_retry) w_next_state = S_IDLE;
          else                            w_next_state = S_GEN;
        end
        S_COMMIT: w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    kill_ready = 1'b1;
    w_commit   = 1'b0;
    if (r_state == S_COMMIT) begin
      kill_ready = 1'b0;
      w_commit   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr       <= c_lfsr_seed;
      r_tick_cnt   <= '0;
      r_spawn_req  <= 1'b0;
      r_ptr        <= '0;
      r_target     <= '0;
      r_cand_x     <= '0;
      r_cand_y     <= '0;
      r_retry      <= '0;
      enemy_active <= '0;
      enemy_x_flat <= '0;
      enemy_y_flat <= '0;
      active_count <= '0;
      spawn_pulse  <= 1'b0;
    end else begin
      r_lfsr      <= w_lfsr_next;
      spawn_pulse <= 1'b0;
      if (clear_all) begin
        enemy_active <= '0;
        active_count <= '0;
        r_spawn_req  <= 1'b0;
        r_retry      <= '0;
        r_tick_cnt   <= '0;
      end else begin
        if (tick) r_tick_cnt <= w_tick_wrap ? 16'd0 : r_tick_cnt + 16'd1;
        // A fresh request landing on the same cycle the old one retires stays pending.
        if (w_tick_wrap)     r_spawn_req <= 1'b1;
        else if (w_req_done) r_spawn_req <= 1'b0;

        case (r_state)
          S_IDLE: r_ptr <= '0;
          S_SCAN: begin
            if (!w_slot_busy) r_target <= r_ptr;
            else              r_ptr    <= r_ptr + 4'd1;
          end
          S_GEN: begin
            r_cand_x <= (w_rx >= c_x_span) ? (w_rx - c_x_span) : w_rx;
            r_cand_y <= (w_ry >= c_y_span) ? (w_ry - c_y_span) : w_ry;
          end
          S_CHECK: begin
            if (w_reject) r_retry <= (r_retry == c_max_retry) ? 8'd0 : r_retry + 8'd1;
          end
          S_COMMIT: begin
            spawn_pulse <= 1'b1;
            r_retry     <= '0;
          end
          default: ;
        endcase

        for (int i = 0; i < MAX_ENEMIES; i++) begin
          if (w_commit_mask[i]) begin
            enemy_x_flat[10*i +: 10] <= r_cand_x;
            enemy_y_flat[10*i +: 10] <= r_cand_y;
          end
        end
        enemy_active <= (enemy_active | w_commit_mask) & ~w_kill_mask;
        if (w_commit)          active_count <= active_count + 4'd1;
        else if (|w_kill_mask) active_count <= active_count - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_enemy_spawner.sv
// Scoreboard bench for enemy_spawner: expected spawns queued at stimulus time, popped by a monitor.
`default_nettype none

module tb_enemy_spawner;
  localparam int N = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick = 1'b0;
  logic           clear_all = 1'b0;
  logic [9:0]     player_x = 10'd1000;
  logic [9:0]     player_y = 10'd1000;
  logic           kill_valid = 1'b0;
  logic [3:0]     kill_idx = 4'd0;
  logic           kill_ready;
  logic [N-1:0]   enemy_active;
  logic [10*N-1:0] enemy_x_flat;
  logic [10*N-1:0] enemy_y_flat;
  logic [3:0]     active_count;
  logic           spawn_pulse;

  always #5 clk = ~clk;

  enemy_spawner #(
    .MAX_ENEMIES(N), .SPAWN_TICKS(4), .SCREEN_W(640), .SCREEN_H(480),
    .ENEMY_SIZE(20), .SAFE_MARGIN(40), .MAX_RETRY(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear_all(clear_all),
    .player_x(player_x), .player_y(player_y),
    .kill_valid(kill_valid), .kill_idx(kill_idx), .kill_ready(kill_ready),
    .enemy_active(enemy_active), .enemy_x_flat(enemy_x_flat), .enemy_y_flat(enemy_y_flat),
    .active_count(active_count), .spawn_pulse(spawn_pulse)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  int           exp_slot[$];
  int           exp_cnt[$];
  logic [N-1:0] exp_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every spawn_pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && spawn_pulse) begin
      if (exp_slot.size() == 0) begin
        check("unexpected_spawn", 32'd1, 32'd0);
      end else begin
        int s, c;
        s = exp_slot.pop_front();
        c = exp_cnt.pop_front();
        exp_mask[s] = 1'b1;
        check("spawn_mask", 32'(enemy_active), 32'(exp_mask));
        check("spawn_count", 32'(active_count), 32'(c));
        check("spawn_x_range", 32'(enemy_x_flat[10*s +: 10] <= 10'd619), 32'd1);
        check("spawn_y_range", 32'(enemy_y_flat[10*s +: 10] <= 10'd459), 32'd1);
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_slot.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("spawn_timeout", 32'(exp_slot.size()), 32'd0);
    exp_slot.delete();
    exp_cnt.delete();
  endtask

  task automatic expect_spawn(input int s, input int c);
    exp_slot.push_back(s);
    exp_cnt.push_back(c);
    ticks(4);
    wait_drain();
  endtask

  task automatic kill(input int idx);
    @(negedge clk);
    kill_valid = 1'b1;
    kill_idx   = 4'(idx);
    check("kill_ready", 32'(kill_ready), 32'd1);
    @(negedge clk);
    kill_valid = 1'b0;
  endtask

`ifdef ENEMY_SPAWN_SAFE_ZONE_EN
  logic           sz_kill_ready;
  logic [N-1:0]   sz_active;
  logic [10*N-1:0] sz_x;
  logic [10*N-1:0] sz_y;
  logic [3:0]     sz_count;
  logic           sz_spawn;
  logic [9:0]     sz_px = 10'd300;
  logic [9:0]     sz_py = 10'd220;
  logic           sz_kv = 1'b0;
  logic [3:0]     sz_ki = 4'd0;

  // Margin covers the whole screen: every candidate rejected, no spawn ever.
  enemy_spawner #(
    .MAX_ENEMIES(N), .SPAWN_TICKS(4), .SCREEN_W(640), .SCREEN_H(480),
    .ENEMY_SIZE(20), .SAFE_MARGIN(600), .MAX_RETRY(7)
  ) dut_sz (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear_all(clear_all),
    .player_x(sz_px), .player_y(sz_py),
    .kill_valid(sz_kv), .kill_idx(sz_ki), .kill_ready(sz_kill_ready),
    .enemy_active(sz_active), .enemy_x_flat(sz_x), .enemy_y_flat(sz_y),
    .active_count(sz_count), .spawn_pulse(sz_spawn)
  );

  always @(negedge clk) begin
    if (rst_n && sz_spawn) check("sz_spawn", 32'd1, 32'd0);
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_active", 32'(enemy_active), 32'd0);
    check("rst_count", 32'(active_count), 32'd0);
    check("rst_pulse", 32'(spawn_pulse), 32'd0);
    check("rst_kill_ready", 32'(kill_ready), 32'd1);
    check("rst_pos", 32'((enemy_x_flat == '0) && (enemy_y_flat == '0)), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < N; i++) expect_spawn(i, i + 1);
    check("full_mask", 32'(enemy_active), 32'h3FF);

    // Table full: the attempt scans all slots and is dropped.
    ticks(4);
    repeat (30) @(negedge clk);
    check("full_count", 32'(active_count), 32'd10);
    check("full_mask_hold", 32'(enemy_active), 32'h3FF);

    kill(3);
    exp_mask[3] = 1'b0;
    check("kill3_mask", 32'(enemy_active), 32'(exp_mask));
    check("kill3_count", 32'(active_count), 32'd9);

    kill(12);
    check("kill12_mask", 32'(enemy_active), 32'(exp_mask));
    check("kill12_count", 32'(active_count), 32'd9);

    expect_spawn(3, 10);

    kill(5);
    exp_mask[5] = 1'b0;
    check("kill5_count", 32'(active_count), 32'd9);
    kill(5);
    check("kill5_again_mask", 32'(enemy_active), 32'(exp_mask));
    check("kill5_again_count", 32'(active_count), 32'd9);

    // First free slot is 5: GEN occupies the cycle after the 7th edge past the tick.
    ticks(4);
    repeat (7) @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    exp_mask = '0;
    check("clear_active", 32'(enemy_active), 32'd0);
    check("clear_count", 32'(active_count), 32'd0);
    repeat (20) @(negedge clk);
    check("clear_no_spawn", 32'(enemy_active), 32'd0);

    for (int i = 0; i < 3; i++) expect_spawn(i, i + 1);

    // Reset lands while SCAN walks slots 0..3.
    ticks(4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_mask = '0;
    check("arst_active", 32'(enemy_active), 32'd0);
    check("arst_count", 32'(active_count), 32'd0);
    check("arst_pulse", 32'(spawn_pulse), 32'd0);
    check("arst_kill_ready", 32'(kill_ready), 32'd1);
    check("arst_pos", 32'((enemy_x_flat == '0) && (enemy_y_flat == '0)), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    expect_spawn(0, 1);

`ifdef ENEMY_SPAWN_SAFE_ZONE_EN
    ticks(4);
    repeat (40) @(negedge clk);
    check("sz_count", 32'(sz_count), 32'd0);
    check("sz_active", 32'(sz_active), 32'd0);
    check("sz_kill_ready", 32'(sz_kill_ready), 32'd1);
    check("sz_pos", 32'((sz_x == '0) && (sz_y == '0)), 32'd1);
`endif

    repeat (30) @(negedge clk);
    check("queue_empty", 32'(exp_slot.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
